// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use stall, branch flush,
// and data-memory wait handling with a timeout and event counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       pcsrcM,
  input  logic       memreqM,
  input  logic       memreadyM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       memerr,
  output logic [15:0] stallcnt,
  output logic [15:0] flushcnt
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [7:0] WLAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  waitcnt_q, waitcnt_d;
  logic        memerr_q, memerr_d;
  logic [15:0] stallcnt_q, stallcnt_d;
  logic [15:0] flushcnt_q, flushcnt_d;

  logic lwstall;
  logic tmo;
  logic memdone;
  logic memhold;

  // Operand forwarding: newest producer (M) wins over W; r0 never forwards.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rsE != 5'd0 && regwriteM && writeregM == rsE)
      forwardAE = 2'b10;
    else if (rsE != 5'd0 && regwriteW && writeregW == rsE)
      forwardAE = 2'b01;
    if (rtE != 5'd0 && regwriteM && writeregM == rtE)
      forwardBE = 2'b10;
    else if (rtE != 5'd0 && regwriteW && writeregW == rtE)
      forwardBE = 2'b01;
  end

  // Load-use hazard and memory completion / hold conditions.
  always_comb begin
    lwstall = regwriteE && memtoregE && writeregE != 5'd0
              && (writeregE == rsD || writeregE == rtD);
    tmo     = (state_q == S_WAIT) && (waitcnt_q == WLAST);
    memdone = memreadyM || tmo;
    memhold = memreqM && !memdone;
  end

  // Wait FSM state, wait counter, sticky error and event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      waitcnt_q  <= 8'd0;
      memerr_q   <= 1'b0;
      stallcnt_q <= 16'd0;
      flushcnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      waitcnt_q  <= waitcnt_d;
      memerr_q   <= memerr_d;
      stallcnt_q <= stallcnt_d;
      flushcnt_q <= flushcnt_d;
    end
  end

  // Next state: enter WAIT on a held access, leave on done or abandon.
  always_comb begin
    state_d   = state_q;
    waitcnt_d = waitcnt_q;
    memerr_d  = memerr_q;
    unique case (state_q)
      S_RUN: begin
        if (memhold) begin
          state_d   = S_WAIT;
          waitcnt_d = 8'd0;
        end
      end
      S_WAIT: begin
        if (memdone || !memreqM) begin
          state_d = S_RUN;
          if (memreqM && tmo && !memreadyM)
            memerr_d = 1'b1;
        end else begin
          waitcnt_d = waitcnt_q + 8'd1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Stall/flush priority: reset, memory hold, branch, load-use.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (reset) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else if (memhold) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (pcsrcM) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (lwstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // Saturating stall and flush event counters.
  always_comb begin
    stallcnt_d = stallcnt_q;
    flushcnt_d = flushcnt_q;
    if (stallF && stallcnt_q != 16'hFFFF)
      stallcnt_d = stallcnt_q + 16'd1;
    if (flushE && flushcnt_q != 16'hFFFF)
      flushcnt_d = flushcnt_q + 16'd1;
  end

  assign memerr   = memerr_q;
  assign stallcnt = stallcnt_q;
  assign flushcnt = flushcnt_q;

endmodule
